// File: rtl/div_sequencer_if.sv
// Handshake and data bundle between the execute stage and the divide sequencer.
// The master side is the decode/control path; the slave side is the sequencer.
interface div_sequencer_if #(
    parameter int XLEN = 64
);
    logic            start_i;
    logic [1:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, word_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, word_i, a_i, b_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; the pipeline is stalled until the result is ready.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   S_IDLE | waiting for an op; latches operands on start_i & ~flush_i
//   S_CALC | one restoring iteration per cycle, counter runs N..1
//   S_FIN  | sign fix and quotient/remainder select, registers result_o
module div_sequencer #(
    parameter int XLEN = 64
) (
    input  logic          clk_i,
    input  logic          arst_i,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dsr_q;
    logic            is_rem_q;
    logic            word_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            signed_op;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] a_min;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] a_align;
    logic            b_zero;
    logic            ovf;
    logic [CW-1:0]   n_init;

    logic [XLEN:0]   trial;
    logic            qbit;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;

    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] sel;
    logic [XLEN-1:0] result_d;

    // Issue-cycle operand conditioning: effective-width extension, magnitudes, special cases
    always_comb begin
        signed_op = ~bus.op_i[0];
        if (bus.word_i) begin
            a_ext  = signed_op ? {{(XLEN-32){bus.a_i[31]}}, bus.a_i[31:0]}
                               : {{(XLEN-32){1'b0}}, bus.a_i[31:0]};
            b_ext  = signed_op ? {{(XLEN-32){bus.b_i[31]}}, bus.b_i[31:0]}
                               : {{(XLEN-32){1'b0}}, bus.b_i[31:0]};
            a_min  = {{(XLEN-31){1'b1}}, {31{1'b0}}};
            n_init = CW'(32);
        end else begin
            a_ext  = bus.a_i;
            b_ext  = bus.b_i;
            a_min  = {1'b1, {(XLEN-1){1'b0}}};
            n_init = CW'(XLEN);
        end
        a_neg   = signed_op & a_ext[XLEN-1];
        b_neg   = signed_op & b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        b_zero  = (b_ext == '0);
        ovf     = signed_op & (a_ext == a_min) & (&b_ext);
        // W dividends are left-aligned so the 32 iterations consume the meaningful bits first
        a_align = bus.word_i ? (a_mag << 32) : a_mag;
    end

    // One restoring step: shift the next dividend bit in and try subtracting the divisor
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
        qbit  = ~trial[XLEN];
        rem_d = qbit ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_d = {quo_q[XLEN-2:0], qbit};
    end

    // Final sign correction, quotient/remainder select and W-result sign extension
    always_comb begin
        quo_fix  = neg_quo_q ? -quo_q : quo_q;
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
        sel      = is_rem_q ? rem_fix : quo_fix;
        result_d = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    // Sequencer FSM with its counter, datapath registers and registered outputs
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            is_rem_q  <= 1'b0;
            word_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // start_i is still high in the done cycle for the op just finished
                    if (bus.start_i && !bus.flush_i && !done_q) begin
                        is_rem_q <= bus.op_i[1];
                        word_q   <= bus.word_i;
                        dsr_q    <= b_mag;
                        if (b_zero) begin
                            quo_q     <= '1;
                            rem_q     <= a_ext;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= S_FIN;
                        end else if (ovf) begin
                            quo_q     <= a_ext;
                            rem_q     <= '0;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= S_FIN;
                        end else begin
                            quo_q     <= a_align;
                            rem_q     <= '0;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            cnt_q     <= n_init;
                            state_q   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    if (!bus.flush_i) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    // Released in the done cycle so the pipeline advances; forced low while in reset
    assign bus.stall_o  = ~arst_i & ~done_q &
                          ((bus.start_i & ~bus.flush_i & (state_q == S_IDLE)) |
                           (state_q == S_CALC) | (state_q == S_FIN));
endmodule
